// File: rtl/fsm_enable_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fsm_enable_arbiter
// Description : Grants the state machine's enable E to one of N requesters,
//               pulses E for the requested step count, settles one cycle and
//               returns the captured {A,B,Q} with a one-cycle DONE pulse.
//               Define FSM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//               otherwise the lowest-index requester wins (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_enable_arbiter #(
    parameter int N      = 4,
    parameter int STEP_W = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N-1:0]        REQ,
    input  logic [N*STEP_W-1:0] STEPS,
    output logic [N-1:0]        GNT,
    output logic [N-1:0]        DONE,
    output logic [2:0]          RESULT,
    output logic                BUSY,
    output logic                E,
    input  logic                A,
    input  logic                B,
    input  logic                Q
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [STEP_W-1:0]   r_cnt;
    logic [PTR_W-1:0]    r_win;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        r_done;
    logic [2:0]          r_result;
    logic                r_busy;
    logic                r_e;

    logic                w_found;
    logic [PTR_W-1:0]    w_win;
    logic [STEP_W-1:0]   w_steps;

`ifdef FSM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_idx;

    // Search starts at the pointer and wraps; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N);
            if (!w_found && REQ[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr <= '0;
        end else if (r_state == S_FIN) begin
            r_ptr <= (r_win == PTR_W'(N - 1)) ? '0 : r_win + 1'b1;
        end
    end
`else
    // Scanning downward leaves the lowest requesting index as the winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (REQ[k]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(k);
            end
        end
    end
`endif

    always_comb begin
        w_steps = '0;
        for (int k = 0; k < N; k++) begin
            if (w_win == PTR_W'(k)) begin
                w_steps = STEPS[k*STEP_W +: STEP_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = (w_steps != '0) ? S_RUN : S_SETTLE;
                end
            end
            S_RUN: begin
                if (r_cnt == STEP_W'(1)) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_win    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_e      <= 1'b0;
        end else begin
            r_state <= w_next;
            // E, BUSY and DONE follow the next state so they line up with it.
            r_e     <= (w_next == S_RUN);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_FIN) ? (N'(1) << r_win) : '0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_win;
                        r_cnt <= w_steps;
                        r_gnt <= N'(1) << w_win;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                S_SETTLE: begin
                    r_result <= {A, B, Q};
                end
                S_FIN: begin
                    r_gnt <= '0;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign GNT    = r_gnt;
    assign DONE   = r_done;
    assign RESULT = r_result;
    assign BUSY   = r_busy;
    assign E      = r_e;

endmodule
`default_nettype wire

// File: tb/tb_fsm_enable_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_enable_arbiter
// Description : Directed bench for fsm_enable_arbiter with a transaction-level
//               reference model and a small stand-in state machine on E.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_enable_arbiter;

    localparam int N  = 4;
    localparam int SW = 4;

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b0;
    logic [N-1:0]    REQ   = '0;
    logic [N*SW-1:0] STEPS = '0;
    logic [N-1:0]    GNT;
    logic [N-1:0]    DONE;
    logic [2:0]      RESULT;
    logic            BUSY;
    logic            E;
    logic            A, B, Q;
    logic [2:0]      abq;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_enable_arbiter #(.N(N), .STEP_W(SW)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .STEPS(STEPS),
        .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .BUSY(BUSY), .E(E),
        .A(A), .B(B), .Q(Q)
    );

    always #5 CLK = ~CLK;

    // Stand-in state machine: one step along a fixed 8-state cycle per E.
    function automatic logic [2:0] sm_next(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            3'd7:    return 3'd5;
            3'd5:    return 3'd4;
            3'd4:    return 3'd6;
            3'd6:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) abq <= 3'd0;
        else if (E) abq <= sm_next(abq);
    end
    assign {A, B, Q} = abq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: {A,B,Q} after k enable steps from reset, and one
    // grant tracked as (winner, step count, cycle-within-grant).
    int          ord [8] = '{0, 2, 3, 7, 5, 4, 6, 1};
    bit          m_active = 0;
    int          m_w = 0, m_s = 0, m_t = 0, m_ptr = 0, m_steps = 0;
    logic [2:0]  m_result = 3'd0;

    always @(negedge CLK) begin
        logic          exp_e, exp_busy;
        logic [N-1:0]  exp_gnt, exp_done;
        bit            found;
        if (!RST_N) begin
            check("rst_E", {31'd0, E}, 32'd0);
            check("rst_GNT", {28'd0, GNT}, 32'd0);
            check("rst_DONE", {28'd0, DONE}, 32'd0);
            check("rst_BUSY", {31'd0, BUSY}, 32'd0);
            check("rst_RESULT", {29'd0, RESULT}, 32'd0);
            m_active = 0; m_ptr = 0; m_steps = 0; m_result = 3'd0; m_t = 0;
        end else begin
            exp_e    = m_active && (m_t >= 1) && (m_t <= m_s);
            exp_busy = m_active;
            exp_gnt  = m_active ? N'(1 << m_w) : '0;
            exp_done = (m_active && m_t == m_s + 2) ? N'(1 << m_w) : '0;
            check("model_E", {31'd0, E}, {31'd0, exp_e});
            check("model_GNT", {28'd0, GNT}, {28'd0, exp_gnt});
            check("model_DONE", {28'd0, DONE}, {28'd0, exp_done});
            check("model_BUSY", {31'd0, BUSY}, {31'd0, exp_busy});
            check("model_RESULT", {29'd0, RESULT}, {29'd0, m_result});

            if (m_active) begin
                if (exp_e) m_steps++;
                if (m_t == m_s + 1) m_result = 3'(ord[m_steps % 8]);
                if (m_t == m_s + 2) begin
                    m_active = 0;
`ifdef FSM_ARB_ROUND_ROBIN_EN
                    m_ptr = (m_w + 1) % N;
`endif
                end else begin
                    m_t++;
                end
            end else if (REQ != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && REQ[(m_ptr + k) % N]) begin
                        found = 1;
                        m_w   = (m_ptr + k) % N;
                    end
                end
                m_s      = int'(STEPS[m_w*SW +: SW]);
                m_t      = 1;
                m_active = 1;
            end
        end
    end

    // Called in an IDLE cycle (1 time unit after the edge); that cycle is 0.
    task automatic run_txn(input logic [N-1:0] req, input int idx, input logic [SW-1:0] s,
                           input int drop_at, output int done_cyc, output int e_cnt,
                           output int gnt_cnt, output logic [N-1:0] done_vec);
        REQ = req;
        STEPS[idx*SW +: SW] = s;
        done_cyc = -1; e_cnt = 0; gnt_cnt = 0; done_vec = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            if (k == drop_at) begin
                REQ = '0;
                STEPS[idx*SW +: SW] = '0;
            end
            if (E) e_cnt++;
            if (GNT != '0) gnt_cnt++;
            if (DONE != '0) begin
                done_cyc = k;
                done_vec = DONE;
                REQ = '0;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        int dc, ec, gc;
        logic [N-1:0] dv;
        int win [4];
        int cyc [4];
        int nd;
        int exp_win [4];

        #1;
        check("reset_E", {31'd0, E}, 32'd0);
        check("reset_GNT", {28'd0, GNT}, 32'd0);
        check("reset_BUSY", {31'd0, BUSY}, 32'd0);
        check("reset_RESULT", {29'd0, RESULT}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Single request, one step
        run_txn(4'b0001, 0, 4'd1, 0, dc, ec, gc, dv);
        check("single_done_cycle", dc, 3);
        check("single_e_cycles", ec, 1);
        check("single_gnt_cycles", gc, 3);
        check("single_done_vec", {28'd0, dv}, 32'b0001);
        check("single_result", {29'd0, RESULT}, 32'b010);

        // Zero steps
        run_txn(4'b0100, 2, 4'd0, 0, dc, ec, gc, dv);
        check("zero_done_cycle", dc, 2);
        check("zero_e_cycles", ec, 0);
        check("zero_done_vec", {28'd0, dv}, 32'b0100);
        check("zero_result", {29'd0, RESULT}, 32'b010);

        // Request and STEPS withdrawn during RUN
        run_txn(4'b0010, 1, 4'd5, 2, dc, ec, gc, dv);
        check("withdraw_done_cycle", dc, 7);
        check("withdraw_e_cycles", ec, 5);
        check("withdraw_done_vec", {28'd0, dv}, 32'b0010);

        // Asynchronous reset in RUN cycle 2
        REQ = 4'b1000;
        STEPS[3*SW +: SW] = 4'd4;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("midrun_e_before", {31'd0, E}, 32'd1);
        RST_N = 1'b0;
        #1;
        check("midrun_E", {31'd0, E}, 32'd0);
        check("midrun_GNT", {28'd0, GNT}, 32'd0);
        check("midrun_BUSY", {31'd0, BUSY}, 32'd0);
        check("midrun_RESULT", {29'd0, RESULT}, 32'd0);
        check("midrun_DONE", {28'd0, DONE}, 32'd0);
        REQ = '0;
        STEPS = '0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Contention, all requesters at two steps
`ifdef FSM_ARB_ROUND_ROBIN_EN
        exp_win = '{0, 1, 3, 0};
`else
        exp_win = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            win[i] = -1;
            cyc[i] = -1;
        end
        nd = 0;
        REQ = 4'b1011;
        STEPS = {4{4'd2}};
        for (int k = 1; k <= 60 && nd < 4; k++) begin
            @(posedge CLK); #1;
            if (DONE != '0) begin
                for (int j = 0; j < N; j++) if (DONE[j]) win[nd] = j;
                cyc[nd] = k;
                nd++;
                if (nd == 4) REQ = '0;
            end
        end
        @(posedge CLK); #1;
        STEPS = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("contend_winner_%0d", i), win[i], exp_win[i]);
            check($sformatf("contend_cycle_%0d", i), cyc[i], 4 + 5 * i);
        end

        // Maximum step count
        run_txn(4'b0100, 2, 4'hF, 0, dc, ec, gc, dv);
        check("max_done_cycle", dc, 17);
        check("max_e_cycles", ec, 15);
        check("max_done_vec", {28'd0, dv}, 32'b0100);
        check("max_result", {29'd0, RESULT}, 32'b001);

        repeat (3) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
